// File: rtl/hht_mem_resp_if.sv
// hht_mem_resp_if: loader / control-block bus for the HHT response memory.
// Holds the init handshake, the loader write port and the two read ports.
// With HHT_MEM_RDCNT_EN defined, the per-port hit counters are carried as well.
interface hht_mem_resp_if;
  logic        mem_init;
  logic        ready;
  logic        WR;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic [31:0] addr1;
  logic [31:0] dataIn1;
  logic [31:0] addr2;
  logic [31:0] dataIn2;
`ifdef HHT_MEM_RDCNT_EN
  logic [31:0] rd_cnt1;
  logic [31:0] rd_cnt2;
`endif

  modport master (
    output mem_init, WR, wr_addr, wr_data, addr1, addr2,
    input  ready, wr_err, dataIn1, dataIn2
`ifdef HHT_MEM_RDCNT_EN
    , input rd_cnt1, rd_cnt2
`endif
  );

  modport slave (
    input  mem_init, WR, wr_addr, wr_data, addr1, addr2,
    output ready, wr_err, dataIn1, dataIn2
`ifdef HHT_MEM_RDCNT_EN
    , output rd_cnt1, rd_cnt2
`endif
  );
endinterface

// File: rtl/hht_mem_resp.sv
// hht_mem_resp: two-bank word memory (column bank, vector bank) serving the
// HHT control block. After reset or mem_init every word is cleared, one per
// cycle, before the banks are served. Reads are combinational (RD_LAT=0) or
// registered (RD_LAT=1) and return DEF_DATA on a miss or while not ready.
// Optional feature macro: HHT_MEM_RDCNT_EN adds saturating per-port hit
// counters rd_cnt1 / rd_cnt2.
module hht_mem_resp #(
  parameter int unsigned COL_BASE = 180,
  parameter int unsigned COL_SIZE = 230,
  parameter int unsigned V_BASE   = 2,
  parameter int unsigned V_SIZE   = 16,
  parameter int unsigned RD_LAT   = 0,
  parameter logic [31:0] DEF_DATA = 32'd99999
) (
  input  logic           Clk,
  input  logic           Rst,
  hht_mem_resp_if.slave  bus
);

  localparam int unsigned TOTAL  = COL_SIZE + V_SIZE;
  localparam int          CIDX_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int          VIDX_W = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        wr_err_q, wr_err_d;
  logic        clr_en, col_we, vec_we;

  logic [31:0] col_mem [COL_SIZE];
  logic [31:0] vec_mem [V_SIZE];

  // Unsigned window test; the subtraction only happens once a >= base, so no wrap
  function automatic logic in_bank(input logic [31:0] a, input logic [31:0] base,
                                   input logic [31:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction

  logic [31:0] off1, off2, woff_c, woff_v, clr_voff;
  logic        rd1_hit, rd2_hit, wr_col_hit, wr_vec_hit;
  logic [31:0] rd1_val, rd2_val;
  logic        unused_bits;

  assign off1     = bus.addr1 - COL_BASE;
  assign off2     = bus.addr2 - V_BASE;
  assign woff_c   = bus.wr_addr - COL_BASE;
  assign woff_v   = bus.wr_addr - V_BASE;
  assign clr_voff = cnt_q - COL_SIZE;

  assign rd1_hit    = in_bank(bus.addr1, COL_BASE, COL_SIZE);
  assign rd2_hit    = in_bank(bus.addr2, V_BASE, V_SIZE);
  assign wr_col_hit = in_bank(bus.wr_addr, COL_BASE, COL_SIZE);
  assign wr_vec_hit = in_bank(bus.wr_addr, V_BASE, V_SIZE);

  // Offsets are only used after a range hit, so their upper bits carry no information
  assign unused_bits = ^{off1[31:CIDX_W], off2[31:VIDX_W], woff_c[31:CIDX_W],
                         woff_v[31:VIDX_W], clr_voff[31:VIDX_W]};

  // State, clear counter and error pulse registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Next state: clear sequence in INIT, loader writes and miss detection in READY
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_err_d = 1'b0;
    clr_en   = 1'b0;
    col_we   = 1'b0;
    vec_we   = 1'b0;
    case (state_q)
      INIT: begin
        clr_en = 1'b1;
        if (bus.mem_init) begin
          cnt_d = '0;
        end else if (cnt_q == TOTAL - 1) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      READY: begin
        if (bus.WR) begin
          col_we   = wr_col_hit;
          vec_we   = wr_vec_hit;
          wr_err_d = !wr_col_hit && !wr_vec_hit;
        end
        if (bus.mem_init) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Bank storage: zero fill during INIT (column words first), loader writes in READY
  always_ff @(posedge Clk) begin
    if (clr_en) begin
      if (cnt_q < COL_SIZE) col_mem[cnt_q[CIDX_W-1:0]] <= '0;
      else                  vec_mem[clr_voff[VIDX_W-1:0]] <= '0;
    end
    if (col_we) col_mem[woff_c[CIDX_W-1:0]] <= bus.wr_data;
    if (vec_we) vec_mem[woff_v[VIDX_W-1:0]] <= bus.wr_data;
  end

  assign rd1_val = (state_q == READY && rd1_hit) ? col_mem[off1[CIDX_W-1:0]] : DEF_DATA;
  assign rd2_val = (state_q == READY && rd2_hit) ? vec_mem[off2[VIDX_W-1:0]] : DEF_DATA;

  assign bus.ready  = (state_q == READY);
  assign bus.wr_err = wr_err_q;

  generate
    if (RD_LAT == 0) begin : g_rd_comb
      assign bus.dataIn1 = rd1_val;
      assign bus.dataIn2 = rd2_val;
    end else begin : g_rd_reg
      logic [31:0] rd1_p1, rd2_p1;
      // Read data captured at the edge; pre-edge memory contents give old-word semantics
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          rd1_p1 <= DEF_DATA;
          rd2_p1 <= DEF_DATA;
        end else begin
          rd1_p1 <= rd1_val;
          rd2_p1 <= rd2_val;
        end
      end
      assign bus.dataIn1 = rd1_p1;
      assign bus.dataIn2 = rd2_p1;
    end
  endgenerate

`ifdef HHT_MEM_RDCNT_EN
  logic [31:0] rd_cnt1_q, rd_cnt2_q;

  // Per-port count of READY cycles with a bank hit, saturating at all-ones
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_cnt1_q <= '0;
      rd_cnt2_q <= '0;
    end else if (bus.mem_init) begin
      rd_cnt1_q <= '0;
      rd_cnt2_q <= '0;
    end else begin
      if (state_q == READY && rd1_hit && rd_cnt1_q != '1) rd_cnt1_q <= rd_cnt1_q + 32'd1;
      if (state_q == READY && rd2_hit && rd_cnt2_q != '1) rd_cnt2_q <= rd_cnt2_q + 32'd1;
    end
  end

  assign bus.rd_cnt1 = rd_cnt1_q;
  assign bus.rd_cnt2 = rd_cnt2_q;
`endif

endmodule

// File: doc/hht_mem_resp.md
HHT_MEM_RESP -- requirements
Module: hht_mem_resp

Interface
REQ-001 Parameters SHALL be: COL_BASE, default 180, first column-bank word address; COL_SIZE, default 230, column-bank depth; V_BASE, default 2, first vector-bank word address; V_SIZE, default 16, vector-bank depth; RD_LAT, default 0, read latency (0 or 1); DEF_DATA, default 32'd99999, miss/not-ready read value.
REQ-002 Clk  in  1  single clock; all state rising-edge.
REQ-003 Rst  in  1  asynchronous active-low reset.
REQ-004 mem_init  in  1  pulse: start clearing both banks.
REQ-005 ready  out  1  high when banks are initialised and serving.
REQ-006 WR  in  1  write strobe, loader side.
REQ-007 wr_addr  in  32  write word address; bank is selected by address.
REQ-008 wr_data  in  32  write data.
REQ-009 wr_err  out  1  one-cycle pulse: accepted write strobe with address outside both banks.
REQ-010 addr1  in  32  column-bank read address (the control block's addr1).
REQ-011 dataIn1  out  32  column-bank read data.
REQ-012 addr2  in  32  vector-bank read address (the control block's addr2).
REQ-013 dataIn2  out  32  vector-bank read data.

Function
REQ-014 State machine SHALL have states INIT, READY; after reset the state is INIT with clear counter 0.
REQ-015 In INIT, one word SHALL be cleared to 0 per cycle: column words first, then vector words; total COL_SIZE+V_SIZE cycles; after the last word, transition to READY.
REQ-016 ready SHALL be high only in READY.
REQ-017 mem_init sampled high in READY SHALL return to INIT with counter 0; mem_init high in INIT SHALL restart the counter at 0.
REQ-018 WR in READY with COL_BASE<=wr_addr<COL_BASE+COL_SIZE SHALL write column word wr_addr-COL_BASE at the clock edge; the vector range is handled the same way.
REQ-019 WR in READY with an address in neither range SHALL leave memory unchanged and pulse wr_err the next cycle.
REQ-020 WR in INIT SHALL be ignored, with no wr_err.
REQ-021 Range compares SHALL be unsigned 32-bit with no wrap-around; an address one past the last word is a miss.
REQ-022 When RD_LAT=0, dataIn1 SHALL reflect addr1 combinationally.
REQ-023 When RD_LAT=1, dataIn1 SHALL be registered and reflect the addr1 value sampled at the previous edge; port 2 follows the same rule.
REQ-024 Reads SHALL return DEF_DATA when the address misses the port's bank or the state is not READY.
REQ-025 A same-cycle write and read of one word SHALL return the old word; the new word is visible from the next cycle.
REQ-026 Ports 1 and 2 SHALL be independent and never stall.

Reset
REQ-027 Rst low SHALL immediately force: state INIT, counter 0, ready 0, wr_err 0, registered read data DEF_DATA; memory contents are undefined until INIT completes.
REQ-028 Reset asserted mid-INIT or mid-write SHALL abort the operation; no partial write completes after Rst rises.

Configuration
REQ-029 Macro HHT_MEM_RDCNT_EN defined SHALL add outputs rd_cnt1[31:0] and rd_cnt2[31:0]: each counts READY cycles whose port address hits its bank, saturates at all-ones, and is cleared by reset or mem_init.
REQ-030 Without HHT_MEM_RDCNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Release reset -> ready rises exactly 246 cycles later (defaults); reads before then return 99999.
REQ-032 Write 15 to address 180 and 7 to address 2, then addr1=180, addr2=2 -> dataIn1=15, dataIn2=7 (RD_LAT=0 same cycle; RD_LAT=1 next cycle).
REQ-033 addr1=410, addr1=179, addr2=18 -> each reads 99999; WR to address 500 -> wr_err pulses 1 cycle and memory is unchanged.
REQ-034 Same-cycle write of 9 to address 200 while reading addr1=200 -> old value that cycle, 9 the next.
REQ-035 mem_init in READY after loads -> ready falls; after 246 cycles all hit reads return 0.
REQ-036 Rst low during INIT and again during READY -> outputs take reset values immediately; with HHT_MEM_RDCNT_EN, 5 hit cycles give rd_cnt1=5, and reset clears it to 0.
